control_ajuste: RTL and testbench

//  Consumes the debounced button levels (au, dis, sel) and sequences edits to NUM_CAMPOS adjustable values.
//  - sel cycles the active field.
//  - au/dis step the active field up/down, with wrap.
//  - A held au/dis auto-repeats.

---
 rtl/control_ajuste_pkg.sv | 20 ++
 rtl/control_ajuste_detector_flanco.sv | 22 ++
 rtl/control_ajuste.sv | 165 ++++++++++++++++
 tb/tb_control_ajuste.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_ajuste_pkg.sv
// Shared definitions for the field-adjust controller: FSM encodings and the
// wrap-around step helper used by every field.
package control_ajuste_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REP_AU  = 2'd1;
    localparam logic [1:0] ST_REP_DIS = 2'd2;
    localparam logic [1:0] ST_BLOQUEO = 2'd3;

    // One step up or down with wrap between 0 and max_v.
    function automatic logic [31:0] paso(input logic [31:0] v,
                                         input logic        up,
                                         input logic [31:0] max_v);
        if (up) begin
            return (v == max_v) ? 32'd0 : v + 32'd1;
        end
        return (v == 32'd0) ? max_v : v - 32'd1;
    endfunction

endpackage

// File: rtl/control_ajuste_detector_flanco.sv
// Single-bit rising-edge detector; the history register resets high so a level
// already present when reset is released is not seen as a new press.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= in;
        end
    end

    assign rise = in & ~prev_reg;

endmodule

// File: rtl/control_ajuste.sv
// Button-driven editor for NUM_CAMPOS wrap-around values: sel picks the field,
// au/dis step it, and a held au/dis auto-repeats after HOLD_CYCLES.
module control_ajuste
    import control_ajuste_pkg::*;
#(
    parameter int NUM_CAMPOS    = 3,
    parameter int ANCHO         = 8,
    parameter int MAX_VAL       = 99,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        au,
    input  logic                        dis,
    input  logic                        sel,
    output logic [1:0]                  campo,
    output logic [NUM_CAMPOS*ANCHO-1:0] valores,
    output logic                        cambio
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LIM   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LIM = CW'(REPEAT_CYCLES - 1);
    localparam logic [1:0]    CAMPO_ULT  = 2'(NUM_CAMPOS - 1);

    logic rise_au, rise_dis, rise_sel;

    detector_flanco u_det_au (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (au),
        .rise (rise_au)
    );

    detector_flanco u_det_dis (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (dis),
        .rise (rise_dis)
    );

    detector_flanco u_det_sel (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (sel),
        .rise (rise_sel)
    );

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          first_reg, first_next;
    logic [1:0]    campo_reg, campo_next;
    logic          cambio_reg;
    logic          step_up, step_dn;
    logic [CW-1:0] limite;

    // first_reg selects the long initial hold versus the shorter repeat period.
    assign limite = first_reg ? HOLD_LIM : REPEAT_LIM;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        first_next = first_reg;
        campo_next = campo_reg;
        step_up    = 1'b0;
        step_dn    = 1'b0;

        if (rise_sel) begin
            campo_next = (campo_reg == CAMPO_ULT) ? 2'd0 : campo_reg + 2'd1;
            cnt_next   = '0;
            state_next = ST_BLOQUEO;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (au && dis) begin
                        state_next = ST_BLOQUEO;
                    end else if (rise_au) begin
                        step_up    = 1'b1;
                        cnt_next   = '0;
                        first_next = 1'b1;
                        state_next = ST_REP_AU;
                    end else if (rise_dis) begin
                        step_dn    = 1'b1;
                        cnt_next   = '0;
                        first_next = 1'b1;
                        state_next = ST_REP_DIS;
                    end
                end
                ST_REP_AU: begin
                    if (!au) begin
                        state_next = ST_IDLE;
                    end else if (dis) begin
                        state_next = ST_BLOQUEO;
                    end else if (cnt_reg == limite) begin
                        step_up    = 1'b1;
                        cnt_next   = '0;
                        first_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_REP_DIS: begin
                    if (!dis) begin
                        state_next = ST_IDLE;
                    end else if (au) begin
                        state_next = ST_BLOQUEO;
                    end else if (cnt_reg == limite) begin
                        step_dn    = 1'b1;
                        cnt_next   = '0;
                        first_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (!au && !dis) begin
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            first_reg  <= 1'b1;
            campo_reg  <= 2'd0;
            cambio_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            first_reg  <= first_next;
            campo_reg  <= campo_next;
            cambio_reg <= rise_sel | step_up | step_dn;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CAMPOS; gi++) begin : g_campo
            logic [ANCHO-1:0] valor_reg;
            logic [ANCHO-1:0] valor_next;

            assign valor_next = ANCHO'(paso(32'(valor_reg), step_up, 32'(MAX_VAL)));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valor_reg <= '0;
                end else if ((step_up || step_dn) && campo_reg == 2'(gi)) begin
                    valor_reg <= valor_next;
                end
            end

            assign valores[gi*ANCHO +: ANCHO] = valor_reg;
        end
    endgenerate

    assign campo  = campo_reg;
    assign cambio = cambio_reg;

endmodule

// File: tb/tb_control_ajuste.sv
// Randomised plus directed bench for control_ajuste: a press-duration reference
// model predicts every cambio event and a monitor checks each one as it appears.
module tb_control_ajuste;

    localparam int NC     = 3;
    localparam int W      = 8;
    localparam int MAXV   = 9;
    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    logic            clk = 1'b0;
    logic            rst_n, au, dis, sel;
    logic [1:0]      campo;
    logic [NC*W-1:0] valores;
    logic            cambio;

    control_ajuste #(
        .NUM_CAMPOS   (NC),
        .ANCHO        (W),
        .MAX_VAL      (MAXV),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .au     (au),
        .dis    (dis),
        .sel    (sel),
        .campo  (campo),
        .valores(valores),
        .cambio (cambio)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        int campo;
        int v0;
        int v1;
        int v2;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    bit   done     = 0;

    // Reference model: tracks how long the current press has lasted rather than a counter.
    localparam int M_NONE = 0, M_UP = 1, M_DOWN = 2, M_BLOCK = 3;
    int m_vals[NC];
    int m_campo, m_mode, m_held;
    bit m_pa, m_pd, m_ps;

    function automatic int wrap(input int v, input int delta);
        return (v + delta + (MAXV + 1)) % (MAXV + 1);
    endfunction

    task automatic model_edge(input bit a, input bit d, input bit s, input bit r, input int stamp);
        bit ra, rd, rs, ev;
        evt_t e;
        ev = 0;
        if (!r) begin
            foreach (m_vals[i]) m_vals[i] = 0;
            m_campo = 0; m_mode = M_NONE; m_held = 0;
            m_pa = 1; m_pd = 1; m_ps = 1;
            return;
        end
        ra = a && !m_pa; rd = d && !m_pd; rs = s && !m_ps;
        if (rs) begin
            m_campo = (m_campo + 1) % NC;
            m_mode  = M_BLOCK;
            ev = 1;
        end else if (m_mode == M_NONE) begin
            if (a && d) m_mode = M_BLOCK;
            else if (ra) begin
                m_vals[m_campo] = wrap(m_vals[m_campo], 1); m_mode = M_UP; m_held = 0; ev = 1;
            end else if (rd) begin
                m_vals[m_campo] = wrap(m_vals[m_campo], -1); m_mode = M_DOWN; m_held = 0; ev = 1;
            end
        end else if (m_mode == M_UP || m_mode == M_DOWN) begin
            bit own, other;
            own   = (m_mode == M_UP) ? a : d;
            other = (m_mode == M_UP) ? d : a;
            if (!own) m_mode = M_NONE;
            else if (other) m_mode = M_BLOCK;
            else begin
                m_held++;
                if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REPEAT == 0)) begin
                    m_vals[m_campo] = wrap(m_vals[m_campo], (m_mode == M_UP) ? 1 : -1);
                    ev = 1;
                end
            end
        end else if (!a && !d) begin
            m_mode = M_NONE;
        end
        m_pa = a; m_pd = d; m_ps = s;
        if (ev) begin
            e.stamp = stamp; e.campo = m_campo;
            e.v0 = m_vals[0]; e.v1 = m_vals[1]; e.v2 = m_vals[2];
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input bit a, input bit d, input bit s, input bit r);
        au = a; dis = d; sel = s; rst_n = r;
        model_edge(a, d, s, r, edge_cnt + 1);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input bit a, input bit d, input bit s, input int n);
        for (int i = 0; i < n; i++) drive(a, d, s, 1'b1);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (!done && cambio) begin
            evt_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cambio: edge %0d campo=%0d valores=%h, expected no event",
                         edge_cnt, campo, valores);
            end else begin
                e = exp_q.pop_front();
                if (e.stamp != edge_cnt || e.campo != int'(campo) ||
                    e.v0 != int'(valores[7:0]) || e.v1 != int'(valores[15:8]) ||
                    e.v2 != int'(valores[23:16])) begin
                    n_fail++;
                    $display("FAIL cambio_event: got edge %0d campo %0d vals %0d/%0d/%0d, expected edge %0d campo %0d vals %0d/%0d/%0d",
                             edge_cnt, campo, valores[7:0], valores[15:8], valores[23:16],
                             e.stamp, e.campo, e.v0, e.v1, e.v2);
                end else begin
                    $display("event edge %0d campo %0d vals %0d/%0d/%0d ok",
                             edge_cnt, campo, valores[7:0], valores[15:8], valores[23:16]);
                end
            end
        end
    end

    initial begin
        au = 0; dis = 0; sel = 0; rst_n = 0;
        @(posedge clk); #2;
        hold(1'b0, 1'b0, 1'b0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("reset_campo", int'(campo), 0);
        check("reset_valores", int'(valores), 0);
        check("reset_cambio", int'(cambio), 0);

        // 1: short press
        drive(0, 0, 0, 1);
        hold(1, 0, 0, 3);
        hold(0, 0, 0, 2);
        check("t1_field0", int'(valores[7:0]), 1);
        check("t1_campo", int'(campo), 0);

        // 2: wrap both ways (raise field 0 to 9 first)
        for (int i = 0; i < 8; i++) begin
            hold(1, 0, 0, 1);
            hold(0, 0, 0, 1);
        end
        check("t2_at_max", int'(valores[7:0]), 9);
        hold(1, 0, 0, 1); hold(0, 0, 0, 1);
        check("t2_wrap_up", int'(valores[7:0]), 0);
        hold(0, 1, 0, 1); hold(0, 0, 0, 1);
        check("t2_wrap_down", int'(valores[7:0]), 9);

        // 3: auto-repeat from 0
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        hold(1, 0, 0, 28);
        hold(0, 0, 0, 6);
        check("t3_after_hold", int'(valores[7:0]), 6);

        // 4: field selection
        hold(0, 0, 1, 1); hold(0, 0, 0, 1);
        check("t4_campo1", int'(campo), 1);
        hold(0, 0, 1, 1); hold(0, 0, 0, 1);
        check("t4_campo2", int'(campo), 2);
        hold(0, 0, 1, 1); hold(0, 0, 0, 1);
        check("t4_campo0", int'(campo), 0);
        hold(0, 0, 1, 1); hold(0, 0, 0, 1);
        check("t4_campo1b", int'(campo), 1);
        hold(1, 0, 0, 1); hold(0, 0, 0, 2);
        check("t4_field1", int'(valores[15:8]), 1);
        check("t4_field0", int'(valores[7:0]), 6);
        check("t4_field2", int'(valores[23:16]), 0);

        // 5: blocking
        hold(1, 1, 0, 3);
        hold(1, 0, 0, 20);
        hold(0, 0, 0, 2);
        check("t5_blocked", int'(valores[15:8]), 1);
        hold(1, 0, 0, 10);
        hold(1, 1, 0, 12);
        hold(0, 0, 0, 2);
        check("t5_stop", int'(valores[15:8]), 3);

        // 6: reset mid-hold
        hold(1, 0, 0, 14);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        hold(1, 0, 0, 20);
        check("t6_cleared", int'(valores), 0);
        hold(0, 0, 0, 1);
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 2);
        check("t6_repress", int'(valores[7:0]), 1);

        // random
        begin
            bit a = 0, d = 0, s = 0, r;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) == 0) a = ~a;
                if ($urandom_range(0, 14) == 0) d = ~d;
                if ($urandom_range(0, 24) == 0) s = ~s;
                r = ($urandom_range(0, 299) != 0);
                drive(a, d, s, r);
            end
        end
        hold(0, 0, 0, 4);
        done = 1;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
